// File: rtl/axi_stream_packet_length_stripper.sv
// Strips a {ID, LENGTH} header from a 32-bit AXI Stream packet and regenerates TLAST.
// Optional AXIS_STRIPPER_STATS_EN adds saturating good-packet and error counters.
module axi_stream_packet_length_stripper #(
    parameter logic [15:0] ID          = 16'h0000,
    parameter bit          CHECK_ID    = 1'b0,
    parameter bit          ENDIAN_SWAP = 1'b0,
    parameter int unsigned MAX_PKT_LEN = 368
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    input  logic        in_tlast,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    output logic        out_tlast,
    input  logic        out_tready,
    output logic [15:0] hdr_id,
    output logic [15:0] hdr_len,
    output logic        err_len,
    output logic        err_id,
    output logic        err_short,
    output logic        err_long
`ifdef AXIS_STRIPPER_STATS_EN
    ,
    output logic [31:0] pkt_count,
    output logic [31:0] err_count
`endif
);

    typedef enum logic [1:0] {
        S_HEADER,
        S_PAYLOAD,
        S_DISCARD
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] din;
    logic [15:0] w_id;
    logic [15:0] w_len;
    logic        len_bad;
    logic        id_bad;
    logic        last_beat;
    logic        in_xfer;
    logic        ev_len;
    logic        ev_id;
    logic        ev_short;
    logic        ev_long;
    state_t      hdr_next;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign din   = ENDIAN_SWAP ? bswap(in_tdata) : in_tdata;
    assign w_id  = din[31:16];
    assign w_len = din[15:0];

    assign len_bad   = (w_len == 16'd0) || ({16'd0, w_len} > MAX_PKT_LEN);
    assign id_bad    = CHECK_ID && (w_id != ID);
    assign last_beat = (cnt == hdr_len - 16'd1);

    // Payload is a zero-latency pass-through; other states sink words freely.
    always_comb begin
        in_tready  = 1'b1;
        out_tvalid = 1'b0;
        out_tdata  = din;
        out_tlast  = 1'b0;
        if (state == S_PAYLOAD) begin
            in_tready  = out_tready;
            out_tvalid = in_tvalid;
            out_tlast  = last_beat || in_tlast;
        end
    end

    assign in_xfer = in_tvalid && in_tready;

    always_comb begin
        hdr_next = S_PAYLOAD;
        if (in_tlast) begin
            hdr_next = S_HEADER;
        end else if (len_bad || id_bad) begin
            hdr_next = S_DISCARD;
        end
    end

    // A header carrying TLAST reports only as short, whatever its fields hold.
    assign ev_short = in_xfer && in_tlast &&
                      ((state == S_HEADER) ||
                       ((state == S_PAYLOAD) && !last_beat));
    assign ev_len   = in_xfer && (state == S_HEADER) && !in_tlast && len_bad;
    assign ev_id    = in_xfer && (state == S_HEADER) && !in_tlast &&
                      !len_bad && id_bad;
    assign ev_long  = in_xfer && (state == S_PAYLOAD) && last_beat && !in_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HEADER;
            cnt       <= '0;
            hdr_id    <= '0;
            hdr_len   <= '0;
            err_len   <= 1'b0;
            err_id    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_len   <= ev_len;
            err_id    <= ev_id;
            err_short <= ev_short;
            err_long  <= ev_long;
            if (in_xfer) begin
                unique case (state)
                    S_HEADER: begin
                        hdr_id  <= w_id;
                        hdr_len <= w_len;
                        cnt     <= '0;
                        state   <= hdr_next;
                    end
                    S_PAYLOAD: begin
                        cnt <= cnt + 16'd1;
                        if (last_beat && !in_tlast) begin
                            state <= S_DISCARD;
                        end else if (last_beat || in_tlast) begin
                            state <= S_HEADER;
                        end
                    end
                    S_DISCARD: begin
                        if (in_tlast) begin
                            state <= S_HEADER;
                        end
                    end
                    default: state <= S_HEADER;
                endcase
            end
        end
    end

`ifdef AXIS_STRIPPER_STATS_EN
    logic ev_good;
    logic ev_err;

    assign ev_good = in_xfer && (state == S_PAYLOAD) && last_beat && in_tlast;
    assign ev_err  = ev_len || ev_id || ev_short || ev_long;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if (ev_good && (pkt_count != 32'hFFFF_FFFF)) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (ev_err && (err_count != 32'hFFFF_FFFF)) begin
                err_count <= err_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_packet_length_stripper.sv
// Randomized and directed bench for axi_stream_packet_length_stripper.
// A packet-level model predicts output beats and error pulses.
module tb_axi_stream_packet_length_stripper;

    localparam logic [15:0] TB_ID = 16'h0005;
    localparam int          MAXL  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready = 1'b1;
    logic [15:0] hdr_id;
    logic [15:0] hdr_len;
    logic        err_len;
    logic        err_id;
    logic        err_short;
    logic        err_long;

    axi_stream_packet_length_stripper #(
        .ID         (TB_ID),
        .CHECK_ID   (1'b1),
        .ENDIAN_SWAP(1'b1),
        .MAX_PKT_LEN(MAXL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tlast  (in_tlast),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tlast (out_tlast),
        .out_tready(out_tready),
        .hdr_id    (hdr_id),
        .hdr_len   (hdr_len),
        .err_len   (err_len),
        .err_id    (err_id),
        .err_short (err_short),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [3:0]  err_q[$];
    int          errors = 0;
    int          checks = 0;
    int          n_beats = 0;
    int          n_err[4] = '{0, 0, 0, 0};
    logic [31:0] last_out = '0;
    int          rdy_pct = 100;
    int          gap_pct = 0;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // err vector bits: [3]=len [2]=id [1]=short [0]=long
    always @(negedge clk) begin : compare
        beat_t      b;
        logic [3:0] ev;
        if (out_tvalid && out_tready) begin
            n_beats++;
            last_out = out_tdata;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: got %h/%b expected no beat", out_tdata, out_tlast);
            end else begin
                b = exp_q.pop_front();
                if (out_tdata !== b.d || out_tlast !== b.l) begin
                    errors++;
                    $display("FAIL beat: got %h/%b expected %h/%b",
                             out_tdata, out_tlast, b.d, b.l);
                end
            end
        end
        ev = {err_len, err_id, err_short, err_long};
        if (ev != 4'b0000) begin
            for (int k = 0; k < 4; k++) if (ev[k]) n_err[k]++;
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err: got %b expected none", ev);
            end else if (err_q[0] !== ev) begin
                errors++;
                $display("FAIL err: got %b expected %b", ev, err_q[0]);
                void'(err_q.pop_front());
            end else begin
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic model(input logic [15:0] id, input logic [15:0] len,
                         input logic [31:0] p[$]);
        int    n;
        int    m;
        beat_t bt;
        n = p.size();
        if (n == 0) begin
            err_q.push_back(4'b0010);
        end else if (len == 0 || int'(len) > MAXL) begin
            err_q.push_back(4'b1000);
        end else if (id != TB_ID) begin
            err_q.push_back(4'b0100);
        end else begin
            m = (n < int'(len)) ? n : int'(len);
            for (int i = 0; i < m; i++) begin
                bt.d = bswap(p[i]);
                bt.l = (i == m - 1);
                exp_q.push_back(bt);
            end
            if (n < int'(len)) err_q.push_back(4'b0010);
            else if (n > int'(len)) err_q.push_back(4'b0001);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic l);
        int budget;
        bit done;
        in_tdata  = w;
        in_tlast  = l;
        in_tvalid = 1'b1;
        budget = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_tready) begin
                done = 1;
            end else begin
                budget++;
                if (budget > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake: in_tready got 0 expected 1");
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        while ($urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_list(input logic [31:0] raw_hdr, input logic [31:0] p[$]);
        logic [31:0] h;
        h = bswap(raw_hdr);
        model(h[31:16], h[15:0], p);
        send_word(raw_hdr, p.size() == 0);
        for (int i = 0; i < p.size(); i++) send_word(p[i], i == p.size() - 1);
        chk("hdr_id", {16'd0, hdr_id}, {16'd0, h[31:16]});
        chk("hdr_len", {16'd0, hdr_len}, {16'd0, h[15:0]});
    endtask

    task automatic send_rand(input logic [15:0] id, input logic [15:0] len, input int n);
        logic [31:0] p[$];
        for (int i = 0; i < n; i++) p.push_back($urandom());
        send_list(bswap({id, len}), p);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    int          b0;
    int          e0[4];
    logic [31:0] pl[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        chk("rst in_tready", {31'd0, in_tready}, 32'd1);
        chk("rst out_tvalid", {31'd0, out_tvalid}, 32'd0);
        chk("rst hdr_id", {16'd0, hdr_id}, 32'd0);
        chk("rst hdr_len", {16'd0, hdr_len}, 32'd0);
        chk("rst errs", {28'd0, err_len, err_id, err_short, err_long}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // good packet: hdr {5,3}
        b0 = n_beats; e0 = n_err;
        pl = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        send_list(32'h0300_0500, pl);
        settle();
        chk("t1 beats", n_beats - b0, 3);
        chk("t1 errs", (n_err[0] + n_err[1] + n_err[2] + n_err[3])
                       - (e0[0] + e0[1] + e0[2] + e0[3]), 0);
        chk("t1 last data", last_out, 32'hCCBBAA99);
        chk("t1 hdr_len", {16'd0, hdr_len}, 32'd3);

        // short: len 3, tlast on 2nd word
        b0 = n_beats; e0 = n_err;
        send_rand(16'h0005, 16'd3, 2);
        settle();
        chk("t2 beats", n_beats - b0, 2);
        chk("t2 short", n_err[1] - e0[1], 1);

        // long: len 2, 4 words
        b0 = n_beats; e0 = n_err;
        send_rand(16'h0005, 16'd2, 4);
        settle();
        chk("t3 beats", n_beats - b0, 2);
        chk("t3 long", n_err[0] - e0[0], 1);
        chk("t3 in_tready", {31'd0, in_tready}, 32'd1);

        // illegal lengths
        b0 = n_beats; e0 = n_err;
        send_rand(16'h0005, 16'd0, 2);
        send_rand(16'h0005, 16'(MAXL + 1), 1);
        settle();
        chk("t4 beats", n_beats - b0, 0);
        chk("t4 len", n_err[3] - e0[3], 2);

        // id mismatch then match
        b0 = n_beats; e0 = n_err;
        send_rand(16'h0006, 16'd2, 2);
        settle();
        chk("t5 id", n_err[2] - e0[2], 1);
        chk("t5 beats bad", n_beats - b0, 0);
        send_rand(16'h0005, 16'd2, 2);
        settle();
        chk("t5 beats good", n_beats - b0, 2);

        // header-only packet, len 1 and len MAXL
        b0 = n_beats; e0 = n_err;
        send_rand(16'h0005, 16'd4, 0);
        settle();
        chk("t6 hdr short", n_err[1] - e0[1], 1);
        send_rand(16'h0005, 16'd1, 1);
        send_rand(16'h0005, 16'(MAXL), MAXL);
        settle();
        chk("t6 beats", n_beats - b0, 1 + MAXL);

        // backpressure, gaps, swapped raw header {5,2}
        rdy_pct = 50; gap_pct = 40;
        b0 = n_beats;
        pl = '{32'hAABBCCDD, 32'h01020304};
        send_list(32'h0200_0500, pl);
        settle();
        repeat (10) @(posedge clk);
        #1;
        chk("t7 beats", n_beats - b0, 2);
        chk("t7 last data", last_out, 32'h04030201);
        rdy_pct = 100; gap_pct = 0;

        // reset mid-packet
        b0 = n_beats;
        begin
            beat_t bt;
            bt.d = bswap(32'hCAFEF00D);
            bt.l = 1'b0;
            exp_q.push_back(bt);
        end
        send_word(bswap(32'h0005_0005), 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        in_tdata = 32'h12345678;
        in_tvalid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst out_tvalid", {31'd0, out_tvalid}, 32'd0);
        chk("mid rst in_tready", {31'd0, in_tready}, 32'd1);
        chk("mid rst hdr_len", {16'd0, hdr_len}, 32'd0);
        in_tvalid = 1'b0;
        exp_q.delete();
        err_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid rst beats", n_beats - b0, 1);
        b0 = n_beats;
        send_rand(16'h0005, 16'd3, 3);
        settle();
        chk("after rst beats", n_beats - b0, 3);

        // random traffic
        rdy_pct = 70; gap_pct = 30;
        for (int k = 0; k < 80; k++) begin
            logic [15:0] id;
            int          len;
            int          n;
            id  = ($urandom_range(9) == 0) ? 16'h0006 : 16'h0005;
            len = $urandom_range(MAXL + 2);
            if (len >= 1 && len <= MAXL) begin
                n = len + $urandom_range(4) - 2;
                if (n < 0) n = 0;
            end else begin
                n = $urandom_range(3);
            end
            send_rand(id, 16'(len), n);
        end
        rdy_pct = 100;
        repeat (10) @(posedge clk);
        #1;
        chk("drain beats", exp_q.size(), 0);
        chk("drain errs", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
